// File: rtl/exec_alu_pkg.sv
// Shared types for the execute-stage ALU: opcode encoding, divider FSM states, flag bundle.
package exec_alu_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpMul = 3'b010,
    OpDiv = 3'b011,
    OpAnd = 3'b100,
    OpOr  = 3'b101,
    OpXor = 3'b110,
    OpNot = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDivRun,
    StDivFix
  } div_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/exec_alu_divider.sv
// Sequential unsigned restoring divider: one shift/subtract step per cycle, DATA_W steps.
module exec_alu_divider #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  logic              active_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] trial;
  logic              fits;

  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
    fits   = ~trial[DATA_W+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (!stall) begin
      if (start) begin
        active_q <= 1'b1;
        cnt_q    <= CNT_W'(DATA_W);
        rem_q    <= '0;
        quo_q    <= dividend;
        dvs_q    <= divisor;
      end else if (active_q) begin
        if (cnt_q == '0) begin
          active_q <= 1'b0;
        end else begin
          // Remainder stays below the divisor, so the low DATA_W bits are exact.
          rem_q <= fits ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], fits};
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign done     = active_q && (cnt_q == '0);
  assign quotient = quo_q;

endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU with registered result/flags; DIV is iterative when EXEC_ALU_DIV_EN is
// defined, otherwise DIV completes in one cycle and flags overflow to mark it unsupported.
module exec_alu
  import exec_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              div_zero,
  output logic              busy
);

  alu_op_e op;
  logic    accept;
  logic    is_sc;

  assign op     = alu_op_e'(alu_op);
  assign accept = in_valid && in_ready;

  // Single-cycle datapath
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     dif_w;
  logic [2*DATA_W-1:0] prod_w;
  logic [DATA_W-1:0]   sc_res;
  logic                sc_c;
  logic                sc_v;

  always_comb begin
    sum_w  = {1'b0, op_a} + {1'b0, op_b};
    dif_w  = {1'b0, op_a} - {1'b0, op_b};
    prod_w = {{DATA_W{op_a[DATA_W-1]}}, op_a} * {{DATA_W{op_b[DATA_W-1]}}, op_b};
  end

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (op)
      OpAdd: begin
        sc_res = sum_w[DATA_W-1:0];
        sc_c   = sum_w[DATA_W];
        sc_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_w[DATA_W-1] != op_a[DATA_W-1]);
      end
      OpSub: begin
        sc_res = dif_w[DATA_W-1:0];
        sc_c   = dif_w[DATA_W];
        sc_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (dif_w[DATA_W-1] != op_a[DATA_W-1]);
      end
      OpMul: begin
        sc_res = prod_w[DATA_W-1:0];
        // Product fits only if the upper half is a pure sign extension of bit DATA_W-1.
        sc_v   = prod_w[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod_w[DATA_W-1]}};
      end
      OpDiv: begin
`ifndef EXEC_ALU_DIV_EN
        sc_v = 1'b1;
`endif
      end
      OpAnd: sc_res = op_a & op_b;
      OpOr:  sc_res = op_a | op_b;
      OpXor: sc_res = op_a ^ op_b;
      OpNot: sc_res = ~op_a;
    endcase
  end

  logic [DATA_W-1:0] result_d, result_q;
  flags_t            flags_d, flags_q;
  logic              div_zero_d, div_zero_q;
  logic              out_valid_d, out_valid_q;

`ifdef EXEC_ALU_DIV_EN
  div_state_e        state_d, state_q;
  logic              sign_a_q, sign_b_q, b_zero_q;
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W-1:0] div_quo;
  logic              neg;
  logic [DATA_W-1:0] fix_res;
  logic              fix_v;

  assign is_sc     = (op != OpDiv);
  assign div_start = accept && (op == OpDiv);
  assign abs_a     = op_a[DATA_W-1] ? -op_a : op_a;
  assign abs_b     = op_b[DATA_W-1] ? -op_b : op_b;

  exec_alu_divider #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .stall    (stall),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      if (div_start) begin
        sign_a_q <= op_a[DATA_W-1];
        sign_b_q <= op_b[DATA_W-1];
        b_zero_q <= (op_b == '0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (div_start) state_d = StDivRun;
      StDivRun: if (div_done) state_d = StDivFix;
      StDivFix: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle) && !stall;
    busy     = (state_q != StIdle);
  end

  // Truncation toward zero: divide magnitudes, then negate if signs differ.
  always_comb begin
    neg     = sign_a_q ^ sign_b_q;
    fix_res = b_zero_q ? '1 : (neg ? -div_quo : div_quo);
    fix_v   = !b_zero_q && !neg && div_quo[DATA_W-1];
  end
`else
  logic unused_cnt_w;

  assign unused_cnt_w = ^CNT_W;
  assign is_sc        = 1'b1;
  assign in_ready     = !stall;
  assign busy         = 1'b0;
`endif

  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    div_zero_d  = div_zero_q;
    out_valid_d = 1'b0;
    if (accept && is_sc) begin
      result_d    = sc_res;
      flags_d.z   = (sc_res == '0);
      flags_d.n   = sc_res[DATA_W-1];
      flags_d.c   = sc_c;
      flags_d.v   = sc_v;
      div_zero_d  = 1'b0;
      out_valid_d = 1'b1;
    end
`ifdef EXEC_ALU_DIV_EN
    if (state_q == StDivFix) begin
      result_d    = fix_res;
      flags_d.z   = (fix_res == '0);
      flags_d.n   = fix_res[DATA_W-1];
      flags_d.c   = 1'b0;
      flags_d.v   = fix_v;
      div_zero_d  = b_zero_q;
      out_valid_d = 1'b1;
    end
`endif
  end

  // Stall freezes everything, which also defers a pending out_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q && !stall;
  assign result    = result_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_exec_alu.sv
// Directed self-checking bench for exec_alu; DIV scenarios depend on EXEC_ALU_DIV_EN.
module tb_exec_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        stall;
  logic        out_valid;
  logic [15:0] result;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic        div_zero;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  exec_alu #(
    .DATA_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .stall     (stall),
    .out_valid (out_valid),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({out_valid, result, flag_z, flag_n, flag_c, flag_v, div_zero, busy} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h",
               {out_valid, result, flag_z, flag_n, flag_c, flag_v, div_zero, busy}, 22'h0);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  // Each entry: {op, a, b, result, zncv}
  task automatic test_single_cycle();
    logic [54:0] tbl [14];
    logic [20:0] got, exp;
    tbl = '{
      {3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101},
      {3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010},
      {3'b000, 16'h1234, 16'h1111, 16'h2345, 4'b0000},
      {3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110},
      {3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001},
      {3'b001, 16'h5555, 16'h5555, 16'h0000, 4'b1000},
      {3'b010, 16'h0100, 16'h0100, 16'h0000, 4'b1001},
      {3'b010, 16'hFFFD, 16'h0005, 16'hFFF1, 4'b0100},
      {3'b010, 16'h00FF, 16'h0080, 16'h7F80, 4'b0000},
      {3'b010, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101},
      {3'b100, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100},
      {3'b101, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000},
      {3'b110, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b0100},
      {3'b111, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100}
    };
    for (int i = 0; i < 14; i++) begin
      issue(tbl[i][54:52], tbl[i][51:36], tbl[i][35:20]);
      got = {out_valid, result, flag_z, flag_n, flag_c, flag_v};
      exp = {1'b1, tbl[i][19:0]};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL single_cycle[%0d]: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    alu_op   = 3'b001;
    op_a     = 16'h0003;
    op_b     = 16'h0005;
    tick();
    n_vec++;
    if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 16'hFFFE, 4'b0110}) begin
      n_err++;
      $display("FAIL b2b_sub: got %h want %h",
               {out_valid, result, flag_z, flag_n, flag_c, flag_v}, {1'b1, 16'hFFFE, 4'b0110});
    end
    alu_op = 3'b110;
    op_a   = 16'hAAAA;
    op_b   = 16'hAAAA;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, result, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 16'h0000, 4'b1000}) begin
      n_err++;
      $display("FAIL b2b_xor: got %h want %h",
               {out_valid, result, flag_z, flag_n, flag_c, flag_v}, {1'b1, 16'h0000, 4'b1000});
    end
    tick();
    n_vec++;
    if ({out_valid, result, flag_z} !== {1'b0, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_idle_hold: got %h want %h", {out_valid, result, flag_z},
               {1'b0, 16'h0000, 1'b1});
    end
  endtask

  task automatic test_stall_single();
    issue(3'b000, 16'h0001, 16'h0002);
    stall = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL stall_mask: got %b want 00", {out_valid, in_ready});
    end
    tick();
    tick();
    n_vec++;
    if ({out_valid, result} !== {1'b0, 16'h0003}) begin
      n_err++;
      $display("FAIL stall_hold: got %h want %h", {out_valid, result}, {1'b0, 16'h0003});
    end
    stall = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_deferred_pulse: got %b want 1", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_pulse_once: got %b want 0", out_valid);
    end
  endtask

`ifdef EXEC_ALU_DIV_EN
  // Accepts a DIV, optionally stalls ticks (stall_at, stall_at+stall_len], returns latency.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int stall_at,
                         input int stall_len, output int lat, output int ready_hi);
    issue(3'b011, a, b);
    lat      = 0;
    ready_hi = 0;
    for (int k = 1; k <= 60; k++) begin
      stall = (k > stall_at) && (k <= stall_at + stall_len);
      if (in_ready) ready_hi++;
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    stall = 1'b0;
  endtask

  // Each entry: {a, b, result, zncv, div_zero, stall_len, latency}
  task automatic test_div();
    logic [68:0] tbl [5];
    logic [21:0] got, exp;
    int lat, ready_hi;
    tbl = '{
      {16'hFFF9, 16'h0002, 16'hFFFD, 4'b0100, 1'b0, 8'd0, 8'd18},
      {16'h0005, 16'h0000, 16'hFFFF, 4'b0100, 1'b1, 8'd0, 8'd18},
      {16'h8000, 16'hFFFF, 16'h8000, 4'b0101, 1'b0, 8'd0, 8'd18},
      {16'h0064, 16'h0007, 16'h000E, 4'b0000, 1'b0, 8'd5, 8'd23},
      {16'h0007, 16'hFFF9, 16'hFFFF, 4'b0100, 1'b0, 8'd0, 8'd18}
    };
    for (int i = 0; i < 5; i++) begin
      run_div(tbl[i][68:53], tbl[i][52:37], 3, int'(tbl[i][15:8]), lat, ready_hi);
      n_vec++;
      if (lat != int'(tbl[i][7:0]) || ready_hi != 0) begin
        n_err++;
        $display("FAIL div_latency[%0d]: got lat=%0d ready_hi=%0d want lat=%0d ready_hi=0",
                 i, lat, ready_hi, tbl[i][7:0]);
      end
      got = {result, flag_z, flag_n, flag_c, flag_v, div_zero, busy};
      exp = {tbl[i][36:16], 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL div_result[%0d]: got %h want %h", i, got, exp);
      end
    end
    issue(3'b000, 16'h0001, 16'h0001);
    n_vec++;
    if ({out_valid, result, div_zero} !== {1'b1, 16'h0002, 1'b0}) begin
      n_err++;
      $display("FAIL div_zero_clear: got %h want %h", {out_valid, result, div_zero},
               {1'b1, 16'h0002, 1'b0});
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses = 0;
    issue(3'b011, 16'h1234, 16'h0003);
    for (int k = 0; k < 8; k++) tick();
    n_vec++;
    if ({busy, in_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_div_busy: got %b want 10", {busy, in_ready});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({out_valid, result, flag_z, flag_n, flag_c, flag_v, div_zero, busy} !== 22'h0) begin
      n_err++;
      $display("FAIL mid_div_reset: got %h want %h",
               {out_valid, result, flag_z, flag_n, flag_c, flag_v, div_zero, busy}, 22'h0);
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    n_vec++;
    if (pulses != 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_div_discard: got pulses=%0d ready=%b busy=%b want 0/1/0",
               pulses, in_ready, busy);
    end
  endtask
`else
  task automatic test_div_disabled();
    issue(3'b011, 16'h0006, 16'h0003);
    n_vec++;
    if ({out_valid, result, flag_z, flag_n, flag_c, flag_v, div_zero, busy} !==
        {1'b1, 16'h0000, 4'b1001, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL div_disabled: got %h want %h",
               {out_valid, result, flag_z, flag_n, flag_c, flag_v, div_zero, busy},
               {1'b1, 16'h0000, 4'b1001, 1'b0, 1'b0});
    end
    tick();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL div_disabled_ready: got %b want 01", {out_valid, in_ready});
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    alu_op   = 3'b000;
    op_a     = 16'h0;
    op_b     = 16'h0;
    stall    = 1'b0;
    test_reset();
    test_single_cycle();
    test_back_to_back();
    test_stall_single();
`ifdef EXEC_ALU_DIV_EN
    test_div();
    test_reset_mid_div();
`else
    test_div_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
